// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sprite pixel path.
package ppu_pkg;

  localparam int SLOTS_DEF   = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int COLOR_W_DEF = 2;
  localparam int ATTR_W_DEF  = 2;

  // Color index 0 is see-through: background or a lower sprite shows.
  localparam int COLOR_TRANSPARENT = 0;

  // One queued sprite pixel as the mixer sees it.
  typedef struct packed {
    logic                   prio;
    logic                   palette;
    logic [COLOR_W_DEF-1:0] color;
  } obj_pixel_t;

  // MERGE overlays a row on the queue head; APPEND writes at the tail.
  typedef enum logic {
    MODE_MERGE  = 1'b0,
    MODE_APPEND = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/sprite_row_aligner.sv
// Flips a fetched sprite row if requested, then drops the leftmost pixels
// that fall off the left screen edge. Purely combinational.
module sprite_row_aligner
  import ppu_pkg::*;
#(
  parameter int SLOTS   = SLOTS_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic [SLOTS*COLOR_W-1:0]   row_color,
  input  logic                       flip_x,
  input  logic [$clog2(SLOTS)-1:0]   skip,
  output logic [COLOR_W-1:0]         eff_color [SLOTS],
  output logic [$clog2(SLOTS):0]     count
);

  localparam int SKIP_W = $clog2(SLOTS);
  localparam int CNT_W  = SKIP_W + 1;

  logic [COLOR_W-1:0] ordered [SLOTS];
  logic [CNT_W-1:0]   src;

  // Put the row into screen order, mirroring it for x-flipped sprites.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      if (flip_x) ordered[k] = row_color[(SLOTS-1-k)*COLOR_W +: COLOR_W];
      else        ordered[k] = row_color[k*COLOR_W +: COLOR_W];
    end
  end

  // Shift left by the clip amount; slots past the end read as transparent.
  always_comb begin
    src = '0;
    for (int k = 0; k < SLOTS; k++) begin
      src          = CNT_W'(k) + CNT_W'(skip);
      eff_color[k] = COLOR_W'(COLOR_TRANSPARENT);
      if (src < CNT_W'(SLOTS)) eff_color[k] = ordered[src[SKIP_W-1:0]];
    end
  end

  assign count = CNT_W'(SLOTS) - CNT_W'(skip);

endmodule

// File: rtl/sprite_mix_fifo.sv
// Circular sprite pixel queue between the sprite fetcher and the pixel
// mixer. Rows are either overlaid on the queue head (already-visible
// pixels win) or appended at the tail. Evaluation order within a cycle is
// flush, then pop, then push.
module sprite_mix_fifo
  import ppu_pkg::*;
#(
  parameter int SLOTS   = SLOTS_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int ATTR_W  = ATTR_W_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       push_in,
  input  logic                       mode_in,
  input  logic [SLOTS*COLOR_W-1:0]   row_color_in,
  input  logic [ATTR_W-1:0]          row_attr_in,
  input  logic                       flip_x_in,
  input  logic [$clog2(SLOTS)-1:0]   skip_in,
  output logic                       push_ready_out,
  output logic                       overflow_out,
  input  logic                       pop_in,
  output logic [COLOR_W-1:0]         pixel_out,
  output logic [ATTR_W-1:0]          attr_out,
  output logic                       pixel_valid_out,
  output logic [$clog2(DEPTH):0]     occupancy_out
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int CNT_W   = $clog2(SLOTS) + 1;
  localparam int ENTRY_W = ATTR_W + COLOR_W;
  localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(COLOR_TRANSPARENT);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [OCC_W-1:0]   occ;

  logic [COLOR_W-1:0] eff_color [SLOTS];
  logic [CNT_W-1:0]   count;
  logic [OCC_W-1:0]   row_n;
  fifo_mode_e         mode;

  logic [PTR_W-1:0]   rd_base, wr_base, rd_pop, wr_next;
  logic [OCC_W-1:0]   occ_base, occ_pop, occ_next, free_slots;
  logic               pop_take, ready, push_take;

  logic               wr_en   [SLOTS];
  logic [PTR_W-1:0]   wr_addr [SLOTS];
  logic [ENTRY_W-1:0] wr_data [SLOTS];

  sprite_row_aligner #(
    .SLOTS   (SLOTS),
    .COLOR_W (COLOR_W)
  ) u_aligner (
    .row_color (row_color_in),
    .flip_x    (flip_x_in),
    .skip      (skip_in),
    .eff_color (eff_color),
    .count     (count)
  );

  assign row_n          = OCC_W'(count);
  assign mode           = fifo_mode_e'(mode_in);
  assign push_ready_out = ready;
  assign occupancy_out  = occ;

  // Apply flush and pop to the registered state and decide push acceptance.
  always_comb begin
    rd_base    = flush_in ? '0 : rd_ptr;
    wr_base    = flush_in ? '0 : wr_ptr;
    occ_base   = flush_in ? '0 : occ;
    pop_take   = pop_in && !flush_in && (occ != '0);
    rd_pop     = pop_take ? rd_base + PTR_W'(1) : rd_base;
    occ_pop    = pop_take ? occ_base - OCC_W'(1) : occ_base;
    free_slots = OCC_W'(DEPTH) - occ_pop;
    ready      = (mode == MODE_MERGE) || (free_slots >= row_n);
    push_take  = push_in && ready;
  end

  // Per-slot write plan: merge only fills transparent queued pixels with
  // opaque new ones, but anything beyond the current queue is written as-is.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      wr_en[k]   = 1'b0;
      wr_addr[k] = wr_base + PTR_W'(k);
      wr_data[k] = {row_attr_in, eff_color[k]};
      if (push_take && (OCC_W'(k) < row_n)) begin
        if (mode == MODE_MERGE) begin
          wr_addr[k] = rd_pop + PTR_W'(k);
          if (OCC_W'(k) < occ_pop)
            wr_en[k] = (mem[rd_pop + PTR_W'(k)][COLOR_W-1:0] == TRANSP) &&
                       (eff_color[k] != TRANSP);
          else
            wr_en[k] = 1'b1;
        end else begin
          wr_en[k] = 1'b1;
        end
      end
    end
  end

  // Fill level and tail pointer after the push; merge extends the queue
  // only as far as the new row reaches.
  always_comb begin
    occ_next = occ_pop;
    wr_next  = wr_base;
    if (push_take) begin
      if (mode == MODE_MERGE) begin
        occ_next = (occ_pop > row_n) ? occ_pop : row_n;
        wr_next  = rd_pop + occ_next[PTR_W-1:0];
      end else begin
        occ_next = occ_pop + row_n;
        wr_next  = wr_base + row_n[PTR_W-1:0];
      end
    end
  end

  // Pixel storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < SLOTS; k++) begin
      if (wr_en[k]) mem[wr_addr[k]] <= wr_data[k];
    end
  end

  // Pointers, fill level and the registered pop/overflow outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      occ             <= '0;
      pixel_out       <= '0;
      attr_out        <= '0;
      pixel_valid_out <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      rd_ptr          <= rd_pop;
      wr_ptr          <= wr_next;
      occ             <= occ_next;
      pixel_valid_out <= pop_in && !flush_in;
      overflow_out    <= push_in && !ready;
      if (pop_take) begin
        pixel_out <= mem[rd_ptr][COLOR_W-1:0];
        attr_out  <= mem[rd_ptr][ENTRY_W-1:COLOR_W];
      end else begin
        pixel_out <= TRANSP;
        attr_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mix_fifo.sv
// Self-checking bench for sprite_mix_fifo: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_sprite_mix_fifo;

  localparam int SLOTS   = 8;
  localparam int DEPTH   = 16;
  localparam int COLOR_W = 2;
  localparam int ATTR_W  = 2;
  localparam int SKIP_W  = $clog2(SLOTS);
  localparam int ROW_W   = SLOTS * COLOR_W;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               flush_in, push_in, mode_in, flip_x_in, pop_in;
  logic [ROW_W-1:0]   row_color_in;
  logic [ATTR_W-1:0]  row_attr_in;
  logic [SKIP_W-1:0]  skip_in;
  logic               push_ready_out, overflow_out, pixel_valid_out;
  logic [COLOR_W-1:0] pixel_out;
  logic [ATTR_W-1:0]  attr_out;
  logic [$clog2(DEPTH):0] occupancy_out;

  int checks = 0;
  int errors = 0;

  logic [ATTR_W+COLOR_W-1:0] q [$];
  int eff [SLOTS];
  int eff_n;

  sprite_mix_fifo #(
    .SLOTS (SLOTS), .DEPTH (DEPTH), .COLOR_W (COLOR_W), .ATTR_W (ATTR_W)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .push_in         (push_in),
    .mode_in         (mode_in),
    .row_color_in    (row_color_in),
    .row_attr_in     (row_attr_in),
    .flip_x_in       (flip_x_in),
    .skip_in         (skip_in),
    .push_ready_out  (push_ready_out),
    .overflow_out    (overflow_out),
    .pop_in          (pop_in),
    .pixel_out       (pixel_out),
    .attr_out        (attr_out),
    .pixel_valid_out (pixel_valid_out),
    .occupancy_out   (occupancy_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row after flip and left clip, straight from the pixel list.
  task automatic modelAlign(input logic [ROW_W-1:0] row, input logic flip, input logic [SKIP_W-1:0] skip);
    int pix [SLOTS];
    for (int k = 0; k < SLOTS; k++) pix[k] = int'(row[k*COLOR_W +: COLOR_W]);
    eff_n = SLOTS - int'(skip);
    for (int k = 0; k < SLOTS; k++) eff[k] = 0;
    for (int k = 0; k < eff_n; k++)
      eff[k] = flip ? pix[SLOTS-1-(k+int'(skip))] : pix[k+int'(skip)];
  endtask

  // One clock cycle of stimulus with model update and output checks.
  task automatic applyStimulus(input logic fl, input logic pp, input logic ps, input logic md,
                               input logic fx, input logic [SKIP_W-1:0] sk,
                               input logic [ROW_W-1:0] row, input logic [ATTR_W-1:0] at);
    logic [ATTR_W+COLOR_W-1:0] head;
    logic exp_ready, exp_valid, exp_ovf;
    logic [COLOR_W-1:0] exp_pix;
    logic [ATTR_W-1:0]  exp_attr;
    flush_in = fl; pop_in = pp; push_in = ps; mode_in = md;
    flip_x_in = fx; skip_in = sk; row_color_in = row; row_attr_in = at;
    #1;
    modelAlign(row, fx, sk);
    exp_valid = 1'b0; exp_pix = '0; exp_attr = '0;
    if (fl) q.delete();
    else if (pp) begin
      exp_valid = 1'b1;
      if (q.size() > 0) begin
        head = q.pop_front();
        exp_pix = head[COLOR_W-1:0];
        exp_attr = head[ATTR_W+COLOR_W-1:COLOR_W];
      end
    end
    exp_ready = !md || ((DEPTH - q.size()) >= eff_n);
    checkOutput("push_ready", 32'(push_ready_out), 32'(exp_ready));
    exp_ovf = ps && !exp_ready;
    if (ps && exp_ready) begin
      for (int k = 0; k < eff_n; k++) begin
        if (!md && k < q.size()) begin
          if (q[k][COLOR_W-1:0] == '0 && eff[k] != 0) q[k] = {at, COLOR_W'(eff[k])};
        end else begin
          q.push_back({at, COLOR_W'(eff[k])});
        end
      end
    end
    @(posedge clk_in); #1;
    checkOutput("pixel_valid", 32'(pixel_valid_out), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("pixel", 32'(pixel_out), 32'(exp_pix));
      checkOutput("attr", 32'(attr_out), 32'(exp_attr));
    end
    checkOutput("overflow", 32'(overflow_out), 32'(exp_ovf));
    checkOutput("occupancy", 32'(occupancy_out), 32'(q.size()));
  endtask

  task automatic popExpect(input int color, input int attr);
    applyStimulus(0, 1, 0, 0, 0, '0, '0, '0);
    checkOutput("dir_pixel", 32'(pixel_out), 32'(color));
    checkOutput("dir_attr", 32'(attr_out), 32'(attr));
  endtask

  initial begin
    logic [ROW_W-1:0] rrow;
    rst_in = 1'b1; flush_in = 0; push_in = 0; mode_in = 0; flip_x_in = 0;
    pop_in = 0; skip_in = '0; row_color_in = '0; row_attr_in = '0;
    #12;
    checkOutput("rst_valid", 32'(pixel_valid_out), 0);
    checkOutput("rst_pixel", 32'(pixel_out), 0);
    checkOutput("rst_attr", 32'(attr_out), 0);
    checkOutput("rst_ovf", 32'(overflow_out), 0);
    checkOutput("rst_occ", 32'(occupancy_out), 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Pop on empty queue yields a valid transparent pixel.
    popExpect(0, 0);
    checkOutput("empty_valid", 32'(pixel_valid_out), 1);

    // Plain merge into empty queue.
    applyStimulus(0, 0, 1, 0, 0, '0, 16'h3939, 2'd2);
    checkOutput("merge_occ", 32'(occupancy_out), 8);
    popExpect(1, 2); popExpect(2, 2); popExpect(3, 2); popExpect(0, 2);
    popExpect(1, 2); popExpect(2, 2); popExpect(3, 2); popExpect(0, 2);
    checkOutput("merge_drained", 32'(occupancy_out), 0);

    // Overlap: queued opaque pixels win over the new row.
    applyStimulus(0, 0, 1, 0, 0, '0, 16'hA050, 2'd0);
    applyStimulus(0, 0, 1, 0, 0, '0, 16'hFFFF, 2'd1);
    popExpect(3, 1); popExpect(3, 1); popExpect(1, 0); popExpect(1, 0);
    popExpect(3, 1); popExpect(3, 1); popExpect(2, 0); popExpect(2, 0);

    // Flip then clip three pixels.
    applyStimulus(0, 0, 1, 0, 1, 3'd3, 16'h8039, 2'd1);
    checkOutput("flip_occ", 32'(occupancy_out), 5);
    popExpect(0, 1); popExpect(0, 1); popExpect(3, 1); popExpect(2, 1); popExpect(1, 1);

    // Append to full, reject, pop-assisted single pixel, wrap-around drain.
    applyStimulus(0, 0, 1, 1, 0, '0, 16'h1B6C, 2'd3);
    applyStimulus(0, 0, 1, 1, 0, '0, 16'hE4D2, 2'd2);
    checkOutput("app_full", 32'(occupancy_out), 16);
    applyStimulus(0, 0, 1, 1, 0, '0, 16'h5555, 2'd1);
    checkOutput("app_ovf", 32'(overflow_out), 1);
    checkOutput("app_occ16", 32'(occupancy_out), 16);
    applyStimulus(0, 1, 1, 1, 0, 3'd7, 16'h4000, 2'd1);
    checkOutput("app_n1_ovf", 32'(overflow_out), 0);
    checkOutput("app_n1_occ", 32'(occupancy_out), 16);
    applyStimulus(0, 1, 1, 1, 0, '0, 16'hAAAA, 2'd0);
    checkOutput("app_pop8_ovf", 32'(overflow_out), 1);
    checkOutput("app_pop8_occ", 32'(occupancy_out), 15);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0, 0, '0, '0, '0);

    // Flush with same-cycle pop and push.
    applyStimulus(0, 0, 1, 1, 0, 3'd2, 16'hFFFF, 2'd3);
    checkOutput("pre_flush_occ", 32'(occupancy_out), 6);
    applyStimulus(1, 1, 1, 0, 0, 3'd4, 16'h9C00, 2'd2);
    checkOutput("flush_valid", 32'(pixel_valid_out), 0);
    checkOutput("flush_occ", 32'(occupancy_out), 4);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, '0, '0, '0);

    // Asynchronous reset in the middle of traffic.
    applyStimulus(0, 0, 1, 0, 0, '0, 16'hFFFF, 2'd3);
    applyStimulus(0, 1, 0, 0, 0, '0, '0, '0);
    #2; rst_in = 1'b1; #1;
    checkOutput("arst_valid", 32'(pixel_valid_out), 0);
    checkOutput("arst_pixel", 32'(pixel_out), 0);
    checkOutput("arst_attr", 32'(attr_out), 0);
    checkOutput("arst_occ", 32'(occupancy_out), 0);
    q.delete();
    push_in = 1; mode_in = 1; pop_in = 0;
    @(posedge clk_in); #1;
    checkOutput("arst_hold_occ", 32'(occupancy_out), 0);
    rst_in = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, '0, '0, '0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rrow = ROW_W'($urandom);
      applyStimulus(($urandom_range(0, 31) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                    1'($urandom), 1'($urandom), SKIP_W'($urandom), rrow, ATTR_W'($urandom));
    end
    while (q.size() > 0) applyStimulus(0, 1, 0, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
